// File: rtl/return_stack_pkg.sv
// Shared predecode codes, checkpoint record and link-address helper for the return stack.
`ifndef N_PD_BITS
`define N_PD_BITS 3
`endif

package return_stack_pkg;

  localparam int PD_W          = `N_PD_BITS;
  localparam int RS_LG_DEPTH   = 3;

  localparam logic [PD_W-1:0] PD_NONE    = 3'd0;
  localparam logic [PD_W-1:0] PD_CBR     = 3'd1;
  localparam logic [PD_W-1:0] PD_RET     = 3'd2;
  localparam logic [PD_W-1:0] PD_J       = 3'd3;
  localparam logic [PD_W-1:0] PD_JR      = 3'd4;
  localparam logic [PD_W-1:0] PD_JAL     = 3'd5;
  localparam logic [PD_W-1:0] PD_CALL    = 3'd6;
  localparam logic [PD_W-1:0] PD_POPPUSH = 3'd7;

  // Backend-side storage of a return-stack checkpoint.
  typedef struct packed {
    logic [RS_LG_DEPTH-1:0] ptr;
    logic [RS_LG_DEPTH:0]   count;
    logic [63:0]            tos;
  } ckpt_t;

  function automatic logic [63:0] link_addr(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return address stack: pushes links on calls, predicts targets on returns.
// Combinational read and checkpoint outputs; one entry write per cycle; no backpressure.
`ifndef N_PD_BITS
`define N_PD_BITS 3
`endif

module return_stack
  import return_stack_pkg::*;
#(
  parameter int LG_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_valid,
  input  logic [63:0]           fetch_pc,
  input  logic [`N_PD_BITS-1:0] fetch_pd,
  output logic                  pred_valid,
  output logic [63:0]           pred_target,
  output logic [LG_DEPTH-1:0]   ckpt_ptr,
  output logic [LG_DEPTH:0]     ckpt_count,
  output logic [63:0]           ckpt_tos,
  input  logic                  restore_valid,
  input  logic [LG_DEPTH-1:0]   restore_ptr,
  input  logic [LG_DEPTH:0]     restore_count,
  input  logic [63:0]           restore_tos,
  input  logic                  flush
);

  localparam int DEPTH = 2 ** LG_DEPTH;
  localparam logic [LG_DEPTH:0] FULL = {1'b1, {LG_DEPTH{1'b0}}};

  logic [63:0]         entry [DEPTH];
  logic [LG_DEPTH-1:0] tos_ptr, nxt_ptr;
  logic [LG_DEPTH:0]   count, nxt_count;
  logic                wr_en;
  logic [LG_DEPTH-1:0] wr_idx;
  logic [63:0]         wr_dat;
  logic                empty;

  assign empty       = (count == '0);
  assign pred_target = entry[tos_ptr];
  assign pred_valid  = fetch_valid & ((fetch_pd == PD_RET) | (fetch_pd == PD_POPPUSH)) & ~empty;
  assign ckpt_ptr    = tos_ptr;
  assign ckpt_count  = count;
  assign ckpt_tos    = entry[tos_ptr];

  always_comb begin
    nxt_ptr   = tos_ptr;
    nxt_count = count;
    wr_en     = 1'b0;
    wr_idx    = tos_ptr;
    wr_dat    = link_addr(fetch_pc);
    if (flush) begin
      nxt_ptr   = '0;
      nxt_count = '0;
    end else if (restore_valid) begin
      nxt_ptr   = restore_ptr;
      nxt_count = restore_count;
      wr_en     = 1'b1;
      wr_idx    = restore_ptr;
      wr_dat    = restore_tos;
    end else if (fetch_valid) begin
      // A pop+push on an empty stack degrades to a plain push.
      if ((fetch_pd == PD_JAL) || (fetch_pd == PD_CALL) ||
          ((fetch_pd == PD_POPPUSH) && empty)) begin
        nxt_ptr   = tos_ptr + 1'b1;
        nxt_count = (count == FULL) ? count : count + 1'b1;
        wr_en     = 1'b1;
        wr_idx    = tos_ptr + 1'b1;
      end else if ((fetch_pd == PD_RET) && !empty) begin
        nxt_ptr   = tos_ptr - 1'b1;
        nxt_count = count - 1'b1;
      end else if (fetch_pd == PD_POPPUSH) begin
        wr_en     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tos_ptr <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else begin
      tos_ptr <= nxt_ptr;
      count   <= nxt_count;
      if (wr_en) entry[wr_idx] <= wr_dat;
    end
  end

endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
- Consumer of the predecode codes produced for each fetched instruction.
- Maintains a circular return address stack: pushes link addresses on calls and supplies predicted targets on returns.
- Sits in the fetch stage beside the predecode and branch predictors; the backend checkpoints and repairs it on mispredicts.

Parameters:
- LG_DEPTH, 3, log2 of stack entries (DEPTH = 2**LG_DEPTH = 8).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- fetch_valid  in  1  fetch_pc/fetch_pd qualify this cycle
- fetch_pc  in  64  PC of predecoded instruction
- fetch_pd  in  `N_PD_BITS  predecode class (0 none, 1 cond br, 2 ret, 3 j, 4 jr, 5 jal, 6 jalr call, 7 jalr pop+push)
- pred_valid  out  1  pred_target is a usable return prediction this cycle
- pred_target  out  64  predicted return address
- ckpt_ptr  out  LG_DEPTH  pre-update top-of-stack pointer
- ckpt_count  out  LG_DEPTH+1  pre-update occupancy
- ckpt_tos  out  64  pre-update value of entry[ckpt_ptr]
- restore_valid  in  1  repair from checkpoint
- restore_ptr  in  LG_DEPTH  checkpointed pointer
- restore_count  in  LG_DEPTH+1  checkpointed occupancy
- restore_tos  in  64  checkpointed top value
- flush  in  1  empty the stack (context switch / fence.i)

Behaviour:
- State:
  - entry[DEPTH] of 64 bits
  - tos_ptr (LG_DEPTH bits), points at the top valid entry
  - count (0..DEPTH)
- Reset (async): tos_ptr=0, count=0, entries=0. Outputs at reset: pred_valid=0, pred_target=0, ckpt_*=0.
- Link address = fetch_pc+4, 64-bit wrap, no compressed instructions.
- Read path is combinational, same cycle:
  - pred_target = entry[tos_ptr].
  - pred_valid = fetch_valid & (fetch_pd==2 | fetch_pd==7) & (count!=0).
  - When pred_valid=0, pred_target is don't-care but is still driven as entry[tos_ptr].
- ckpt_ptr/ckpt_count/ckpt_tos are combinational copies of current state, sampled by the backend alongside the instruction.
- Updates at posedge clk, only when fetch_valid=1 and no higher-priority event:
  - pd 5 or 6 (push): tos_ptr+1 (mod DEPTH); entry[new ptr]=link; count=min(count+1,DEPTH). When full, the oldest entry is overwritten silently.
  - pd 2 (pop): if count!=0, tos_ptr-1 (mod DEPTH) and count-1. On underflow (count==0) there is no state change.
  - pd 7 (pop+push): if count!=0, entry[tos_ptr]=link, with tos_ptr and count unchanged. If count==0, it behaves as a push.
  - pd 0,1,3,4 and any other value: no change.
- Priority per edge: reset > flush > restore_valid > fetch op.
  - flush: count=0 and tos_ptr=0; entries are kept.
  - restore_valid: tos_ptr=restore_ptr, count=restore_count, entry[restore_ptr]=restore_tos. A fetch op in the same cycle is dropped.
  - pred_valid is still computed from pre-edge state during a flush or restore cycle. Fetch is redirected in that cycle, so the value is don't-care.
- Single-port write: at most one entry is written per cycle.
- No stall or backpressure; an operation is consumed every valid cycle.
- Reset asserted mid-stream clears the stack immediately, independent of clk.

Decomposition:
- Shared package/header:
  - pd code constants PD_NONE=0, PD_CBR=1, PD_RET=2, PD_J=3, PD_JR=4, PD_JAL=5, PD_CALL=6, PD_POPPUSH=7, alongside `N_PD_BITS in machine.vh, so they are shared with predecode.
  - Checkpoint struct {ptr,count,tos} for backend storage.
- No sub-module; the entry array is a flop array written inline. The link adder is inline.

Test Plan:
- Push then return: pd=5 at pc 0x1000, next cycle pd=2 → pred_valid=1, pred_target=0x1004; count returns to 0.
- Nested calls: pd=6 at 0x100, 0x200, 0x300, then three pd=2 → targets 0x304, 0x204, 0x104 in order; a fourth pd=2 → pred_valid=0 with ptr/count unchanged.
- Overflow: 10 pushes at pc 0x10*i, then 8 pops → targets 0x94 down to 0x24, count saturated at 8, ninth pop → pred_valid=0.
- Pop+push: push at 0x40, then pd=7 at 0x80 → pred_target=0x44 and top becomes 0x84 with count 1; pd=2 → 0x84.
- Checkpoint/restore: capture ckpt at count=2 with top 0x44; do two pops and a push at 0x900; restore → next pd=2 returns 0x44 and count=1. A pd=5 fetch in the restore cycle is ignored.
- Flush and async reset: flush with count=3 → pd=2 gives pred_valid=0. Assert reset between clock edges → count=0 and ckpt_*=0 immediately.
